// File: rtl/mux_nway_rr_pkg.sv
// Shared constants and elaboration helpers for the N-way registered mux.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Smallest r with 2**r >= v; used to check that SEL_W can index N channels.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_nway_rr_if.sv
// Producer/consumer bus of the N-way mux: flattened inputs, handshakes,
// selection controls and the registered output.
interface mux_nway_rr_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2
);
   logic                 mode;
   logic [SEL_W-1:0]     sel;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_valid;
   logic [N-1:0]         in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_W-1:0]     out_chan;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_nway_rr_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr,
// wrapping modulo N (not 2**SEL_W).
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   int unsigned cand;

   // Walk offsets 0..N-1 from ptr; the first asserted request wins.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         for (int unsigned j = 0; j < N; j++) begin
            if (!gnt_valid && cand == j && req[j]) begin
               gnt_valid = 1'b1;
               gnt_idx   = SEL_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/mux_nway_rr.sv
// N-channel registered multiplexer with valid/ready handshakes and either
// explicit-select or round-robin arbitration.
// Optional grant counter port enabled by defining MUX_GRANT_CNT_EN.
module mux_nway_rr
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   mux_nway_rr_if.slave     bus
`ifdef MUX_GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] grant_cnt
`endif
);

   generate
      if (N < 2 || N > 16 || clog2(N) > SEL_W || CNT_W < 1) begin : g_param_check
         $error("mux_nway_rr: illegal parameter combination");
      end
   endgenerate

   logic             load_en;
   logic             grant_valid;
   logic             sel_valid;
   logic             rr_valid;
   logic             xfer;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] rr_idx;
   logic [SEL_W-1:0] ptr;
   logic [WIDTH-1:0] grant_data;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] chan_q;
   logic             valid_q;

   // The register refills in the same cycle it drains.
   assign load_en = !valid_q || bus.out_ready;
   assign xfer    = load_en && grant_valid && !reset;

   rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .gnt_idx   (rr_idx),
      .gnt_valid (rr_valid)
   );

   // Explicit select: only indices below N can ever be granted.
   always_comb begin
      sel_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (bus.sel == SEL_W'(i)) sel_valid = bus.in_valid[i];
      end
   end

   // Choose the grant source by mode.
   always_comb begin
      grant       = bus.sel;
      grant_valid = sel_valid;
      if (bus.mode == MODE_RR) begin
         grant       = rr_idx;
         grant_valid = rr_valid;
      end
   end

   // One-hot ready to the granted channel and its data onto the load path.
   always_comb begin
      bus.in_ready = '0;
      grant_data   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SEL_W'(i)) begin
            bus.in_ready[i] = xfer;
            grant_data      = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register and round-robin pointer; a stall freezes both.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr     <= '0;
      end else if (load_en) begin
         if (grant_valid) begin
            data_q  <= grant_data;
            chan_q  <= grant;
            valid_q <= 1'b1;
            if (bus.mode == MODE_RR)
               ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + SEL_W'(1);
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = valid_q;

`ifdef MUX_GRANT_CNT_EN
   // Saturating count of input transfers.
   always_ff @(posedge clk) begin
      if (reset)
         grant_cnt <= '0;
      else if (xfer && grant_cnt != '1)
         grant_cnt <= grant_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_mux_nway_rr.sv
// Testbench for mux_nway_rr: directed scenarios plus randomized traffic,
// all checked against a behavioural reference model.
module tb_mux_nway_rr;
   import mux_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N     = 4;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_nway_rr_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

`ifdef MUX_GRANT_CNT_EN
   logic [CNT_W-1:0] grant_cnt;
`endif

   mux_nway_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MUX_GRANT_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_valid = 0;
   logic [31:0] m_data  = '0;
   int          m_chan  = 0;
   int          m_ptr   = 0;
   int          m_cnt   = 0;

   // granted channel under the current inputs, or -1 for none
   function automatic int exp_grant();
      int s;
      if (bus.mode == MODE_SEL) begin
         s = int'(bus.sel);
         if (s < N && ((bus.in_valid >> s) & 4'd1) != 4'd0) return s;
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         s = (m_ptr + k) % N;
         if (((bus.in_valid >> s) & 4'd1) != 4'd0) return s;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g;
      if (reset) return '0;
      if (m_valid && !bus.out_ready) return '0;
      g = exp_grant();
      if (g < 0) return '0;
      return 4'b0001 << g;
   endfunction

   // advance one clock, updating the model from the inputs seen at the edge
   task automatic tick();
      int g;
      bit load;
      logic [31:0] d;
      g    = exp_grant();
      load = !m_valid || bus.out_ready;
      d    = (g >= 0) ? bus.in_data[g*WIDTH +: WIDTH] : 32'h0;
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_cnt = 0;
      end else if (load) begin
         if (g >= 0) begin
            m_data  = d;
            m_chan  = g;
            m_valid = 1;
            if (bus.mode == MODE_RR) m_ptr = (g + 1) % N;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         end else begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic set_chan(input int i, input logic [31:0] d);
      bus.in_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic load_pattern();
      for (int i = 0; i < N; i++) set_chan(i, 32'h11111111 * i);
   endtask

   task automatic test_reset();
      reset = 1; bus.mode = MODE_SEL; bus.sel = '0; bus.in_valid = 4'b1111;
      bus.out_ready = 1; load_pattern();
      #1;
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
      total++; if (bus.out_chan !== 3'd0) begin bad++; $display("FAIL reset_chan: got %0d want 0", bus.out_chan); end
      // load ch2 and stall it, then reset while held
      reset = 0; bus.sel = 3'd2; bus.in_valid = 4'b0100; set_chan(2, 32'hDEADBEEF); bus.out_ready = 0;
      #1;
      total++; if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL stall_load_ready: got %b want 0100", bus.in_ready); end
      tick();
      total++; if (bus.out_data !== 32'hDEADBEEF || bus.out_chan !== 3'd2 || bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL stall_load: got %h/%0d/%b want deadbeef/2/1", bus.out_data, bus.out_chan, bus.out_valid); end
      #1;
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready: got %b want 0000", bus.in_ready); end
      tick();
      total++; if (bus.out_data !== 32'hDEADBEEF || bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL stall_hold: got %h/%b want deadbeef/1", bus.out_data, bus.out_valid); end
      reset = 1;
      tick();
      reset = 0;
      total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_chan !== 3'd0) begin
         bad++; $display("FAIL reset_mid_stall: got %b/%h/%0d want 0/0/0", bus.out_valid, bus.out_data, bus.out_chan); end
   endtask

   task automatic test_sel_mode();
      bus.mode = MODE_SEL; bus.sel = 3'd1; bus.in_valid = 4'b1111; bus.out_ready = 1; load_pattern();
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (bus.in_ready !== 4'b0010) begin bad++; $display("FAIL sel_ready[%0d]: got %b want 0010", k, bus.in_ready); end
         tick();
         total++; if (bus.out_data !== 32'h11111111 || bus.out_chan !== 3'd1 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL sel_out[%0d]: got %h/%0d/%b want 11111111/1/1", k, bus.out_data, bus.out_chan, bus.out_valid); end
      end
   endtask

   task automatic test_sel_out_of_range();
      bus.mode = MODE_SEL; bus.sel = 3'd5; bus.in_valid = 4'b1111; bus.out_ready = 1;
      #1;
      total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL oob_ready: got %b want 0000", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h11111111 || bus.out_chan !== 3'd1) begin
         bad++; $display("FAIL oob_out: got %b/%h/%0d want 0/11111111/1", bus.out_valid, bus.out_data, bus.out_chan); end
   endtask

   task automatic test_rr_full();
      reset = 1; tick(); reset = 0;
      bus.mode = MODE_RR; bus.in_valid = 4'b1111; bus.out_ready = 1; load_pattern();
      for (int k = 0; k < 8; k++) begin
         #1;
         total++; if (bus.in_ready !== (4'b0001 << (k % 4))) begin
            bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.in_ready, 4'b0001 << (k % 4)); end
         tick();
         total++; if (int'(bus.out_chan) !== k % 4 || bus.out_data !== 32'h11111111 * (k % 4)) begin
            bad++; $display("FAIL rr_chan[%0d]: got %0d/%h want %0d", k, bus.out_chan, bus.out_data, k % 4); end
      end
   endtask

   task automatic test_rr_backpressure();
      logic [3:0] rdy_exp [6] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
      int         chn_exp [6] = '{1, 1, 3, 3, 1, 1};
      reset = 1; tick(); reset = 0;
      bus.mode = MODE_RR; bus.in_valid = 4'b1010; load_pattern();
      for (int k = 0; k < 6; k++) begin
         bus.out_ready = (k % 2 == 0);
         #1;
         total++; if (bus.in_ready !== rdy_exp[k]) begin bad++; $display("FAIL bp_ready[%0d]: got %b want %b", k, bus.in_ready, rdy_exp[k]); end
         tick();
         total++; if (int'(bus.out_chan) !== chn_exp[k] || bus.out_data !== 32'h11111111 * chn_exp[k] || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_out[%0d]: got %0d/%h/%b want %0d", k, bus.out_chan, bus.out_data, bus.out_valid, chn_exp[k]); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         reset         = ($urandom_range(0, 39) == 0);
         bus.mode      = $urandom_range(0, 1) != 0;
         bus.sel       = SEL_W'($urandom_range(0, 7));
         bus.in_valid  = N'($urandom);
         bus.out_ready = $urandom_range(0, 3) != 0;
         for (int i = 0; i < N; i++) set_chan(i, $urandom);
         #1;
         total++; if (bus.in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, bus.in_ready, exp_ready()); end
         tick();
         total++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || int'(bus.out_chan) !== m_chan) begin
            bad++; $display("FAIL rnd_out[%0d]: got %b/%h/%0d want %b/%h/%0d", k, bus.out_valid, bus.out_data, bus.out_chan, m_valid, m_data, m_chan); end
`ifdef MUX_GRANT_CNT_EN
         total++; if (int'(grant_cnt) !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", k, grant_cnt, m_cnt); end
`endif
      end
      reset = 0;
   endtask

`ifdef MUX_GRANT_CNT_EN
   task automatic test_grant_cnt();
      reset = 1; tick(); reset = 0;
      total++; if (grant_cnt !== 4'd0) begin bad++; $display("FAIL cnt_reset: got %0d want 0", grant_cnt); end
      bus.mode = MODE_RR; bus.in_valid = 4'b1111; bus.out_ready = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         total++; if (int'(grant_cnt) !== ((k + 1 > 15) ? 15 : k + 1)) begin
            bad++; $display("FAIL cnt_step[%0d]: got %0d want %0d", k, grant_cnt, (k + 1 > 15) ? 15 : k + 1); end
      end
      reset = 1; tick(); reset = 0;
      total++; if (grant_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clear: got %0d want 0", grant_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1; bus.mode = MODE_SEL; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 0;
      @(posedge clk); #1;
      test_reset();
      test_sel_mode();
      test_sel_out_of_range();
      test_rr_full();
      test_rr_backpressure();
      test_random();
`ifdef MUX_GRANT_CNT_EN
      test_grant_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
